// File: rtl/wb_pkg.sv
// Shared widths and the load-queue entry type for the writeback stage.
package wb_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_load_queue.sv
// Circular queue of pending load writebacks with in-place squash by destination.
// Latency: push/pop/squash take effect at the next clk edge; valid_mask is registered.
// Backpressure: none internally; the owner must not push when count == DEPTH.
module wb_load_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  wb_entry_t                    push_entry,
    input  logic                         pop,
    input  logic                         squash_en,
    input  logic [ADDR_W-1:0]            squash_dest,
    output wb_entry_t                    head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [NUM_REGS-1:0]          valid_mask
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    wb_entry_t             mem     [DEPTH];
    wb_entry_t             mem_nxt [DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CW-1:0]         cnt_nxt;
    logic [NUM_REGS-1:0]   mask_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Popped slots drop their valid bit, so the mask can OR every slot.
    always_comb begin
        mem_nxt  = mem;
        rd_nxt   = rd_ptr;
        wr_nxt   = wr_ptr;
        cnt_nxt  = count;
        mask_nxt = '0;
        if (squash_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem[i].dest == squash_dest) begin
                    mem_nxt[i].valid = 1'b0;
                end
            end
        end
        if (pop) begin
            mem_nxt[rd_ptr].valid = 1'b0;
            rd_nxt = ptr_inc(rd_ptr);
        end
        if (push) begin
            mem_nxt[wr_ptr] = push_entry;
            wr_nxt = ptr_inc(wr_ptr);
        end
        if (push && !pop) begin
            cnt_nxt = count + 1'b1;
        end else if (pop && !push) begin
            cnt_nxt = count - 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_nxt[i].valid) begin
                mask_nxt[mem_nxt[i].dest] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            valid_mask <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rd_ptr     <= rd_nxt;
            wr_ptr     <= wr_nxt;
            count      <= cnt_nxt;
            valid_mask <= mask_nxt;
            mem        <= mem_nxt;
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and load results onto the single register-file write port; ALU always wins.
// Latency: winner chosen in cycle N is presented on reg_write_* in cycle N+1.
// Backpressure: ALU none; loads stall via ld_ready when the load queue is full.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_dest,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [ADDR_W-1:0]   ld_dest,
    input  logic [DATA_W-1:0]   ld_data,
    output logic                reg_write_en,
    output logic [ADDR_W-1:0]   reg_write_dest,
    output logic [DATA_W-1:0]   reg_write_data,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [15:0]         conflict_cnt
);
    localparam int CW = $clog2(LQ_DEPTH + 1);
    localparam logic [CW-1:0] LQ_CNT = CW'(LQ_DEPTH);

    wb_entry_t          q_head, push_entry;
    logic [CW-1:0]      q_count;
    logic               q_nonempty, head_live, ld_acc;
    logic               push, pop;
    logic               win_en;
    logic [ADDR_W-1:0]  win_dest;
    logic [DATA_W-1:0]  win_data;

    assign ld_ready   = !rst && (q_count < LQ_CNT);
    assign ld_acc     = ld_valid && ld_ready;
    assign q_nonempty = (q_count != '0);
    assign head_live  = q_nonempty && q_head.valid;
    assign push_entry = {1'b1, ld_dest, ld_data};

    // A squashed head still consumes the queue slot, blocking the bypass path that cycle.
    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        win_en   = 1'b0;
        win_dest = '0;
        win_data = '0;
        if (alu_valid) begin
            win_en   = 1'b1;
            win_dest = alu_dest;
            win_data = alu_data;
            push     = ld_acc && (ld_dest != alu_dest);
        end else if (q_nonempty) begin
            pop  = 1'b1;
            push = ld_acc;
            if (q_head.valid) begin
                win_en   = 1'b1;
                win_dest = q_head.dest;
                win_data = q_head.data;
            end
        end else if (ld_acc) begin
            win_en   = 1'b1;
            win_dest = ld_dest;
            win_data = ld_data;
        end
    end

    wb_load_queue #(
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .squash_en   (alu_valid),
        .squash_dest (alu_dest),
        .head        (q_head),
        .count       (q_count),
        .valid_mask  (pending_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_en   <= 1'b0;
            reg_write_dest <= '0;
            reg_write_data <= '0;
            conflict_cnt   <= '0;
        end else begin
            reg_write_en   <= win_en;
            reg_write_dest <= win_dest;
            reg_write_data <= win_data;
            if (alu_valid && head_live && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-level model predicts writes, mask, counter and ready.
module tb_wb_arbiter;
    import wb_pkg::*;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, alu_valid, ld_valid, ld_ready, reg_write_en;
    logic [2:0]  alu_dest, ld_dest, reg_write_dest;
    logic [15:0] alu_data, ld_data, reg_write_data, conflict_cnt;
    logic [7:0]  pending_mask;

    always #5 clk = ~clk;

    wb_arbiter #(.LQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data), .pending_mask(pending_mask),
        .conflict_cnt(conflict_cnt)
    );

    typedef struct { logic [2:0] dest; logic [15:0] data; bit live; } ment_t;
    typedef struct { int due; logic [2:0] dest; logic [15:0] data; } wr_t;

    ment_t       mq[$];
    wr_t         exp_q[$];
    int          total = 0, bad = 0, cyc = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  cur_mask = '0, nxt_mask = '0;
    int          cur_cnt = 0, nxt_cnt = 0;
    bit          cur_rdy = 1'b0;
    logic [15:0] m_rf [8];
    logic [15:0] d_rf [8];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_mask();
        logic [7:0] m = '0;
        foreach (mq[i]) if (mq[i].live) m[mq[i].dest] = 1'b1;
        return m;
    endfunction

    function automatic void push_exp(input int due, input logic [2:0] d, input logic [15:0] v);
        wr_t w;
        w.due = due; w.dest = d; w.data = v;
        exp_q.push_back(w);
        m_rf[d] = v;
    endfunction

    // Drive one cycle of inputs and advance the model by the writeback rules.
    task automatic step(input bit r, input bit av, input logic [2:0] ad, input logic [15:0] adat,
                        input bit lv, input logic [2:0] ldd, input logic [15:0] ldat,
                        output bit acc);
        ment_t h, n;
        @(posedge clk); #1;
        cur_mask = nxt_mask;
        cur_cnt  = nxt_cnt;
        cur_rdy  = !r && (mq.size() < DEPTH);
        rst = r; alu_valid = av; alu_dest = ad; alu_data = adat;
        ld_valid = lv; ld_dest = ldd; ld_data = ldat;
        acc = lv && cur_rdy;
        n.dest = ldd; n.data = ldat; n.live = 1'b1;
        if (r) begin
            mq.delete();
            nxt_mask = '0;
            nxt_cnt  = 0;
        end else begin
            if (av && mq.size() > 0 && mq[0].live && nxt_cnt < 65535) nxt_cnt++;
            if (av) begin
                push_exp(cyc + 1, ad, adat);
                foreach (mq[i]) if (mq[i].dest == ad) mq[i].live = 1'b0;
                if (acc && ldd != ad) mq.push_back(n);
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                if (h.live) push_exp(cyc + 1, h.dest, h.data);
                if (acc) mq.push_back(n);
            end else if (acc) begin
                push_exp(cyc + 1, ldd, ldat);
            end
            nxt_mask = model_mask();
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, 3'd0, 16'd0, 0, 3'd0, 16'd0, a);
    endtask

    // Monitor: every cycle compare status outputs; pop the scoreboard when a write is due.
    always @(negedge clk) begin
        if (mon_en) begin
            bit  exp_now;
            wr_t e;
            check("ld_ready", ld_ready, cur_rdy);
            check("pending_mask", pending_mask, cur_mask);
            check("conflict_cnt", conflict_cnt, cur_cnt);
            exp_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("write_en", reg_write_en, exp_now);
            if (exp_now) begin
                e = exp_q.pop_front();
                if (reg_write_en === 1'b1) begin
                    check("write_dest", reg_write_dest, e.dest);
                    check("write_data", reg_write_data, e.data);
                    d_rf[reg_write_dest] = reg_write_data;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bit a;
        int alu_left;
        for (int i = 0; i < 8; i++) begin m_rf[i] = '0; d_rf[i] = '0; end
        rst = 1'b1; alu_valid = 0; alu_dest = 0; alu_data = 0;
        ld_valid = 0; ld_dest = 0; ld_data = 0;

        step(1, 0, 3'd0, 16'd0, 0, 3'd0, 16'd0, a);
        step(1, 0, 3'd0, 16'd0, 0, 3'd0, 16'd0, a);
        mon_en = 1'b1;

        // Reset while an ALU result is offered: nothing must be written.
        step(1, 1, 3'd7, 16'h1234, 1, 3'd6, 16'h4321, a);
        @(negedge clk);
        check("rst_ld_ready", ld_ready, 1'b0);
        idle(1);
        @(negedge clk);
        check("rst_write_en", reg_write_en, 1'b0);
        check("rst_release_ready", ld_ready, 1'b1);

        // Bypass of a load on an idle cycle.
        step(0, 0, 3'd0, 16'd0, 1, 3'd3, 16'hBEEF, a);
        idle(1);
        @(negedge clk);
        check("bypass_dest", reg_write_dest, 3'd3);
        check("bypass_mask", pending_mask, 8'h00);
        idle(2);
        check("bypass_rf", d_rf[3], 16'hBEEF);

        // ALU and load collide: ALU first, load one cycle later.
        step(0, 1, 3'd1, 16'h0011, 1, 3'd2, 16'h0022, a);
        idle(1);
        @(negedge clk);
        check("coll_r1_dest", reg_write_dest, 3'd1);
        check("coll_mask_queued", pending_mask, 8'h04);
        idle(1);
        @(negedge clk);
        check("coll_r2_data", reg_write_data, 16'h0022);
        check("coll_mask_clear", pending_mask, 8'h00);
        check("coll_conflict", conflict_cnt, 16'd0);
        idle(2);

        // Queue fills: third load is held until a slot frees.
        alu_left = 3;
        for (int k = 0; k < 3; k++) begin
            a = 1'b0;
            for (int t = 0; t < 20 && !a; t++) begin
                step(0, alu_left > 0, 3'd0, 16'h1000 + 16'(alu_left), 1, 3'(4 + k), 16'h4000 + 16'(k), a);
                if (alu_left > 0) alu_left--;
            end
            check("full_load_accepted", a, 1'b1);
        end
        idle(4);
        check("full_r4", d_rf[4], 16'h4000);
        check("full_r5", d_rf[5], 16'h4001);
        check("full_r6", d_rf[6], 16'h4002);

        // A queued load is squashed by a younger ALU write to the same register.
        step(0, 1, 3'd1, 16'h0101, 1, 3'd5, 16'h5555, a);
        step(0, 1, 3'd5, 16'hAAAA, 0, 3'd0, 16'd0, a);
        idle(1);
        @(negedge clk);
        check("squash_mask_bit5", pending_mask[5], 1'b0);
        idle(3);
        check("squash_r5", d_rf[5], 16'hAAAA);

        // Reset with two loads queued discards them.
        step(0, 1, 3'd0, 16'h0A0A, 1, 3'd2, 16'h6602, a);
        step(0, 1, 3'd0, 16'h0B0B, 1, 3'd3, 16'h6603, a);
        step(1, 0, 3'd0, 16'd0, 0, 3'd0, 16'd0, a);
        idle(1);
        @(negedge clk);
        check("midrst_mask", pending_mask, 8'h00);
        check("midrst_conflict", conflict_cnt, 16'd0);
        idle(4);
        check("midrst_r2", d_rf[2], 16'h0022);
        check("midrst_r3", d_rf[3], 16'hBEEF);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 45, 3'($urandom_range(0, 7)),
                 16'($urandom), $urandom_range(0, 99) < 55, 3'($urandom_range(0, 7)), 16'($urandom), a);
        end
        idle(6);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        for (int i = 0; i < 8; i++) check("final_rf", d_rf[i], m_rf[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
